capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Capture controller for the analyzer sampling path. It consumes synchronized samples from the input synchronizer plus a trigger-match strobe.
- Writes samples into a circular sample RAM, counts a programmable number of post-trigger samples, then stops.
- On request, streams the captured window out oldest-first over a valid/ready interface.
- Sits between the input synchronizer / trigger logic and the host readout path.

Parameters:
- WIDTH, 8, sample width in bits.
- ADDR_W, 10, sample RAM address width; depth = 2^ADDR_W.

Ports:
- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse: start capture (honoured in IDLE only).
- abort  in  1  return to IDLE from any state.
- sample_valid  in  1  sample strobe from the rate divider.
- sample_in  in  WIDTH  synchronized sample data.
- trigger_hit  in  1  trigger match; qualified by sample_valid.
- delay_count  in  ADDR_W  post-trigger sample count; sampled on the trigger cycle.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address, used for both write and read.
- mem_wdata  out  WIDTH  RAM write data.
- mem_rdata  in  WIDTH  RAM read data, synchronous with 1-cycle latency.
- rd_start  in  1  pulse: begin readout (honoured in DONE only).
- rd_data  out  WIDTH  readout word.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  final word of the window, qualified by rd_valid.
- rd_ready  in  1  consumer accepts a word when rd_valid && rd_ready.
- armed, triggered, done  out  1 each  status flags.

Behaviour:
- Reset:
  - State = IDLE; wr_ptr = 0; wrapped = 0.
  - All outputs = 0.
  - Reset has priority over every other input.
- States: IDLE, ARMED, POST, DONE, RD_ADDR, RD_DATA.
- IDLE:
  - arm -> ARMED next cycle; wr_ptr cleared to 0; wrapped cleared to 0.
- ARMED (armed=1):
  - Each sample_valid: mem_we=1, mem_addr=wr_ptr, mem_wdata=sample_in, all in the same cycle (combinational from the state register).
  - wr_ptr increments mod 2^ADDR_W; wrapped is set when wr_ptr wraps from 2^ADDR_W-1 to 0.
  - trigger_hit without sample_valid is ignored.
  - sample_valid && trigger_hit: the trigger sample is written, and:
    - delay_count==0 -> DONE;
    - otherwise post_cnt <= delay_count and -> POST.
- POST (triggered=1):
  - Each sample_valid writes as in ARMED and decrements post_cnt.
  - The write made with post_cnt==1 is the last one; -> DONE.
  - Net result: exactly delay_count samples are written after the trigger sample.
  - trigger_hit is ignored.
- DONE (done=1, triggered held at 1):
  - No writes.
  - Window start = wrapped ? wr_ptr : 0.
  - Window length = wrapped ? 2^ADDR_W : wr_ptr.
  - rd_start -> RD_ADDR with rd_ptr = start and rd_rem = length.
- RD_ADDR:
  - Drives mem_addr=rd_ptr with mem_we=0.
  - -> RD_DATA next cycle.
- RD_DATA:
  - rd_valid=1; rd_data = mem_rdata, registered/held stable while rd_valid && !rd_ready.
  - rd_last=1 when rd_rem==1.
  - On handshake: rd_ptr increments mod depth and rd_rem decrements.
    - If this was the last word -> IDLE (done cleared).
    - Otherwise -> RD_ADDR.
  - Throughput is 1 word per 2 cycles maximum.
- Arithmetic: rd_rem is ADDR_W+1 bits wide to hold 2^ADDR_W; pointers wrap naturally.
- abort:
  - From any state -> IDLE next cycle.
  - mem_we and rd_valid are forced 0 in the abort cycle; status flags cleared.
  - abort and arm in the same cycle in IDLE: abort wins, stay IDLE.
- Ignored inputs:
  - arm outside IDLE.
  - rd_start outside DONE.
  - sample_valid outside ARMED/POST (mem_we stays 0).

Optional Feature:
- Macro: CAPTURE_SEQ_TRIG_ADDR_EN.
- With the macro defined:
  - Extra output trig_addr[ADDR_W-1:0] is latched with wr_ptr on the trigger write.
  - It holds its value through DONE and readout; reset and arm clear it to 0.
- Without the macro: the port and register are absent; behaviour is otherwise identical.

Test Plan (bench parameters ADDR_W=4, WIDTH=8):
- No wrap:
  - Stimulus: arm; samples 0x10..0x14 with trigger on 0x12; delay_count=2.
  - Required: DONE after the 0x14 write.
  - Required: readout yields 0x10,0x11,0x12,0x13,0x14 with rd_last on 0x14.
  - Required (macro on): trig_addr=2.
- Wrap:
  - Stimulus: 20 samples 0x00..0x13, trigger on 0x0F, delay_count=4.
  - Required: 16 words 0x04..0x13 oldest-first; rd_last on 0x13.
- delay_count=0:
  - Stimulus: trigger on the first sample 0xAA.
  - Required: DONE the next cycle; single word 0xAA with rd_last=1.
- Backpressure:
  - Stimulus: rd_ready low for 5 cycles mid-readout.
  - Required: rd_data and rd_valid stable throughout; no word lost or duplicated.
- abort:
  - Stimulus: abort asserted in POST.
  - Required: IDLE next cycle; mem_we=0; a subsequent rd_start is ignored; a fresh arm restarts at addr 0.
- Qualification and reset:
  - Stimulus: trigger_hit with sample_valid=0 in ARMED.
  - Required: no state change.
  - Stimulus: reset asserted during RD_DATA.
  - Required: all outputs 0 and IDLE next cycle.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: circular sample-RAM capture with post-trigger delay and oldest-first readout.
// Optional macro CAPTURE_SEQ_TRIG_ADDR_EN adds trig_addr, the RAM address of the trigger sample.
module capture_sequencer #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  sample_in,
    input  logic              trigger_hit,
    input  logic [ADDR_W-1:0] delay_count,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              rd_start,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              armed,
    output logic              triggered,
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
`else
    output logic              done
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W:0]   rd_rem;
    logic              wrapped;
    logic              rd_fresh;
    logic [WIDTH-1:0]  rd_hold;
    logic              capturing;
    logic              wr_fire;

    // The RAM word is live only in the first RD_DATA cycle; afterwards the held copy is shown.
    always_comb begin
        capturing = (state == S_ARMED) || (state == S_POST);
        wr_fire   = capturing && sample_valid && !abort && !reset;
        rd_valid  = (state == S_RD_DATA) && !abort && !reset;
        mem_we    = wr_fire;
        mem_wdata = wr_fire ? sample_in : '0;
        mem_addr  = '0;
        if (capturing) begin
            mem_addr = wr_ptr;
        end else if ((state == S_RD_ADDR) || (state == S_RD_DATA)) begin
            mem_addr = rd_ptr;
        end
        rd_data = '0;
        if (rd_valid) begin
            rd_data = rd_fresh ? mem_rdata : rd_hold;
        end
        rd_last   = rd_valid && (rd_rem == REM_ONE);
        armed     = (state == S_ARMED);
        triggered = (state == S_POST) || (state == S_DONE);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            post_cnt <= '0;
            rd_ptr   <= '0;
            rd_rem   <= '0;
            rd_fresh <= 1'b0;
            rd_hold  <= '0;
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
            trig_addr <= '0;
`endif
        end else if (abort) begin
            state    <= S_IDLE;
            rd_fresh <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state   <= S_ARMED;
                        wr_ptr  <= '0;
                        wrapped <= 1'b0;
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
                        trig_addr <= '0;
`endif
                    end
                end
                S_ARMED: begin
                    if (sample_valid) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        if (wr_ptr == '1) wrapped <= 1'b1;
                        if (trigger_hit) begin
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
                            trig_addr <= wr_ptr;
`endif
                            if (delay_count == '0) begin
                                state <= S_DONE;
                            end else begin
                                post_cnt <= delay_count;
                                state    <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (sample_valid) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        if (wr_ptr == '1) wrapped <= 1'b1;
                        if (post_cnt == PTR_ONE) state <= S_DONE;
                        else post_cnt <= post_cnt - PTR_ONE;
                    end
                end
                S_DONE: begin
                    if (rd_start) begin
                        rd_ptr <= wrapped ? wr_ptr : '0;
                        rd_rem <= wrapped ? REM_FULL : {1'b0, wr_ptr};
                        state  <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    rd_fresh <= 1'b1;
                    state    <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    rd_fresh <= 1'b0;
                    if (rd_fresh) rd_hold <= mem_rdata;
                    if (rd_ready) begin
                        rd_ptr <= rd_ptr + PTR_ONE;
                        rd_rem <= rd_rem - REM_ONE;
                        state  <= (rd_rem == REM_ONE) ? S_IDLE : S_RD_ADDR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: transaction-level model (sample history queue,
// readout window queue) compared every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_capture_sequencer;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int M_IDLE = 0, M_WAIT = 1, M_POST = 2, M_HELD = 3, M_FETCH = 4, M_PRESENT = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0, abort = 1'b0, sample_valid = 1'b0, trigger_hit = 1'b0;
    logic              rd_start = 1'b0, rd_ready = 1'b0;
    logic [WIDTH-1:0]  sample_in = '0;
    logic [ADDR_W-1:0] delay_count = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata = '0;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid, rd_last, armed, triggered, done;
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
    logic [ADDR_W-1:0] trig_addr;
`endif

    always #5 clock = ~clock;

    capture_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort),
        .sample_valid(sample_valid), .sample_in(sample_in), .trigger_hit(trigger_hit),
        .delay_count(delay_count), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last(rd_last), .rd_ready(rd_ready), .armed(armed), .triggered(triggered),
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
        .done(done), .trig_addr(trig_addr)
`else
        .done(done)
`endif
    );

    // Synchronous sample RAM, one cycle read latency.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int fails  = 0;
    int mode = M_IDLE;
    int post_left = 0;
    int trig_exp = 0;
    bit check_en = 1'b0;
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] win[$];
    logic [WIDTH-1:0] got[$];
    bit               got_last[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected outputs from history/window queues, then advance on the upcoming edge.
    always @(negedge clock) begin : cmp
        bit wr, rv;
        int exp_addr;
        int first;
        wr = (mode == M_WAIT || mode == M_POST) && sample_valid && !abort && !reset;
        rv = (mode == M_PRESENT) && !abort && !reset;
        if (check_en) begin
            exp_addr = 0;
            if (mode == M_WAIT || mode == M_POST) exp_addr = hist.size() % DEPTH;
            else if (mode == M_FETCH || mode == M_PRESENT) exp_addr = (hist.size() - win.size()) % DEPTH;
            chk("mem_we", 32'(mem_we), 32'(wr));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", 32'(mem_wdata), wr ? 32'(sample_in) : 32'd0);
            chk("rd_valid", 32'(rd_valid), 32'(rv));
            if (rv) begin
                chk("rd_data", 32'(rd_data), 32'(win[0]));
                chk("rd_last", 32'(rd_last), 32'(win.size() == 1));
            end else begin
                chk("rd_data_idle", 32'(rd_data), 32'd0);
                chk("rd_last_idle", 32'(rd_last), 32'd0);
            end
            chk("armed", 32'(armed), 32'(mode == M_WAIT));
            chk("triggered", 32'(triggered), 32'(mode == M_POST || mode == M_HELD));
            chk("done", 32'(done), 32'(mode == M_HELD));
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
            chk("trig_addr", 32'(trig_addr), 32'(trig_exp));
`endif
            if (rv && rd_ready) begin
                got.push_back(rd_data);
                got_last.push_back(rd_last);
            end
        end
        if (reset) begin
            mode = M_IDLE; hist.delete(); win.delete(); trig_exp = 0;
        end else if (abort) begin
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: if (arm) begin mode = M_WAIT; hist.delete(); trig_exp = 0; end
                M_WAIT: if (sample_valid) begin
                    if (trigger_hit) begin
                        trig_exp = hist.size() % DEPTH;
                        if (delay_count == 0) mode = M_HELD;
                        else begin post_left = int'(delay_count); mode = M_POST; end
                    end
                    hist.push_back(sample_in);
                end
                M_POST: if (sample_valid) begin
                    hist.push_back(sample_in);
                    post_left--;
                    if (post_left == 0) mode = M_HELD;
                end
                M_HELD: if (rd_start) begin
                    win.delete();
                    first = (hist.size() > DEPTH) ? hist.size() - DEPTH : 0;
                    for (int i = first; i < hist.size(); i++) win.push_back(hist[i]);
                    mode = M_FETCH;
                end
                M_FETCH: mode = M_PRESENT;
                M_PRESENT: if (rd_ready) begin
                    void'(win.pop_front());
                    mode = (win.size() == 0) ? M_IDLE : M_FETCH;
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] s, input bit t, input int dc);
        sample_valid = 1'b1; sample_in = s; trigger_hit = t; delay_count = ADDR_W'(dc);
        tick();
        sample_valid = 1'b0; trigger_hit = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        #1;
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
        chk({tag, "_flags"}, 32'({armed, triggered, done}), 32'd0);
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
        chk({tag, "_trig_addr"}, 32'(trig_addr), 32'd0);
`endif
    endtask

    // Reads the captured window; stall_at >= 0 drops rd_ready for 5 cycles once that many words are taken.
    task automatic readout(input int stall_at);
        int n;
        bit stalled;
        logic [WIDTH-1:0] v;
        got.delete(); got_last.delete();
        stalled = 1'b0;
        rd_ready = 1'b1; rd_start = 1'b1; tick(); rd_start = 1'b0;
        n = 0;
        while (mode != M_IDLE && n < 100) begin
            if (!stalled && stall_at >= 0 && got.size() == stall_at && mode == M_PRESENT) begin
                stalled = 1'b1;
                rd_ready = 1'b0;
                v = rd_data;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk("stall_valid", 32'(rd_valid), 32'd1);
                    chk("stall_data", 32'(rd_data), 32'(v));
                end
                rd_ready = 1'b1;
            end
            tick();
            n++;
        end
        chk("readout_complete", 32'(mode == M_IDLE), 32'd1);
    endtask

    task automatic check_words(input string tag, input int base, input int count);
        chk({tag, "_count"}, 32'(got.size()), 32'(count));
        for (int i = 0; i < count && i < got.size(); i++) begin
            chk({tag, "_word"}, 32'(got[i]), 32'(base + i));
            chk({tag, "_last"}, 32'(got_last[i]), 32'(i == count - 1));
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_en = 1'b1;
        check_all_zero("reset");

        // No wrap, plus a trigger without sample strobe while armed.
        do_arm();
        chk("t1_armed", 32'(armed), 32'd1);
        trigger_hit = 1'b1; tick(); trigger_hit = 1'b0;
        chk("qual_armed", 32'(armed), 32'd1);
        chk("qual_triggered", 32'(triggered), 32'd0);
        send(8'h10, 1'b0, 0); send(8'h11, 1'b0, 0); send(8'h12, 1'b1, 2);
        chk("t1_triggered", 32'(triggered), 32'd1);
        send(8'h13, 1'b0, 0);
        chk("t1_not_done", 32'(done), 32'd0);
        send(8'h14, 1'b0, 0);
        chk("t1_done", 32'(done), 32'd1);
`ifdef CAPTURE_SEQ_TRIG_ADDR_EN
        chk("t1_trig_addr", 32'(trig_addr), 32'd2);
`endif
        readout(-1);
        check_words("nowrap", 'h10, 5);
        chk("t1_idle_done", 32'(done), 32'd0);

        // Wrap: 20 samples, trigger on 0x0F, delay 4.
        do_arm();
        for (int i = 0; i < 20; i++) send(8'(i), i == 15, 4);
        chk("wrap_done", 32'(done), 32'd1);
        readout(-1);
        check_words("wrap", 'h04, 16);

        // delay_count = 0 on the first sample.
        do_arm();
        send(8'hAA, 1'b1, 0);
        chk("dc0_done", 32'(done), 32'd1);
        readout(-1);
        check_words("dc0", 'hAA, 1);

        // Backpressure mid-readout.
        do_arm();
        send(8'h20, 1'b1, 4);
        for (int i = 1; i < 5; i++) send(8'(8'h20 + i), 1'b0, 0);
        readout(2);
        check_words("bp", 'h20, 5);

        // abort in POST, rd_start afterwards ignored, fresh arm restarts at address 0.
        do_arm();
        send(8'h30, 1'b1, 5);
        send(8'h31, 1'b0, 0);
        chk("ab_post", 32'(triggered), 32'd1);
        abort = 1'b1; sample_valid = 1'b1; sample_in = 8'h32;
        #1;
        chk("ab_mem_we", 32'(mem_we), 32'd0);
        chk("ab_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        abort = 1'b0; sample_valid = 1'b0;
        chk("ab_flags", 32'({armed, triggered, done}), 32'd0);
        rd_start = 1'b1; tick(); rd_start = 1'b0; tick();
        chk("ab_rd_ignored", 32'(rd_valid), 32'd0);
        chk("ab_no_done", 32'(done), 32'd0);
        do_arm();
        sample_valid = 1'b1; sample_in = 8'h55;
        #1;
        chk("rearm_addr", 32'(mem_addr), 32'd0);
        chk("rearm_we", 32'(mem_we), 32'd1);
        tick();
        sample_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("abort_beats_arm", 32'(armed), 32'd0);

        // Reset during RD_DATA.
        do_arm();
        send(8'h40, 1'b1, 1);
        send(8'h41, 1'b0, 0);
        rd_ready = 1'b0; rd_start = 1'b1; tick(); rd_start = 1'b0; tick();
        chk("rst_rd_valid", 32'(rd_valid), 32'd1);
        chk("rst_rd_data", 32'(rd_data), 32'h40);
        reset = 1'b1; tick(); reset = 1'b0;
        check_all_zero("rst_rd");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            arm          = ($urandom_range(0, 99) < 6);
            abort        = ($urandom_range(0, 199) < 2);
            reset        = ($urandom_range(0, 999) < 3);
            sample_valid = ($urandom_range(0, 1) == 1);
            trigger_hit  = ($urandom_range(0, 9) == 0);
            sample_in    = 8'($urandom);
            delay_count  = ADDR_W'($urandom_range(0, 12));
            rd_start     = ($urandom_range(0, 9) < 3);
            rd_ready     = ($urandom_range(0, 9) < 6);
            tick();
        end
        arm = 1'b0; abort = 1'b0; reset = 1'b0; sample_valid = 1'b0;
        trigger_hit = 1'b0; rd_start = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
